// File: rtl/implication_pkg.sv
// rtl/implication_pkg.sv - shared limits for the implication responder
package implication_pkg;
   localparam int LATENCY_MAX = 8;
   localparam int PENDING_MAX = 15;
   localparam int PENDING_W   = 4;
endpackage

// File: rtl/pulse_delay_line.sv
// rtl/pulse_delay_line.sv - DEPTH-cycle single-bit pulse delay, wire when DEPTH=0
module pulse_delay_line #(
   parameter int DEPTH = 1
) (
   input  logic clk,
   input  logic rst,
   input  logic din,
   output logic dout
);

   generate
      if (DEPTH == 0) begin : g_pass
         wire unused_pass = clk | rst;
         assign dout = din;
      end else begin : g_shift
         logic [DEPTH-1:0] stages;

         // Pulses sampled during reset never enter the line.
         always_ff @(posedge clk) begin
            if (rst) stages <= '0;
            else     stages <= (stages << 1) | DEPTH'(din);
         end

         assign dout = stages[DEPTH-1];
      end
   endgenerate

endmodule

// File: rtl/implication_responder.sv
// rtl/implication_responder.sv - issues one consequent per antecedent after LATENCY cycles
module implication_responder
   import implication_pkg::*;
#(
   parameter int LATENCY      = 1,
   parameter int MAX_PENDING  = 4,
   parameter int EMBED_CHECKS = 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 antecedent,
   input  logic                 consequent_ready,
   output logic                 consequent,
   output logic [PENDING_W-1:0] pending,
   output logic                 overflow
);

   generate
      if (LATENCY < 0 || LATENCY > LATENCY_MAX) begin : g_bad_latency
         $fatal(1, "implication_responder: LATENCY out of range 0..8");
      end
      if (MAX_PENDING < 1 || MAX_PENDING > PENDING_MAX) begin : g_bad_pending
         $fatal(1, "implication_responder: MAX_PENDING out of range 1..15");
      end
   endgenerate

   logic               due_now;
   logic               avail;
   logic [PENDING_W:0] next_sum;

   pulse_delay_line #(.DEPTH(LATENCY)) u_delay (
      .clk  (clk),
      .rst  (rst),
      .din  (antecedent),
      .dout (due_now)
   );

   assign avail      = (pending != '0) || due_now;
   assign consequent = avail && consequent_ready;

   // One extra bit so a due pulse on a full counter is seen as overflow, not a wrap.
   assign next_sum = {1'b0, pending} + (PENDING_W+1)'(due_now) - (PENDING_W+1)'(consequent);

   always_ff @(posedge clk) begin
      if (rst) begin
         pending  <= '0;
         overflow <= 1'b0;
      end else if (next_sum > (PENDING_W+1)'(MAX_PENDING)) begin
         pending  <= PENDING_W'(MAX_PENDING);
         overflow <= 1'b1;
      end else begin
         pending  <= next_sum[PENDING_W-1:0];
      end
   end

   generate
      if (EMBED_CHECKS != 0) begin : g_checks
         logic past_valid;
         logic expect_due;

         always_ff @(posedge clk) begin
            if (rst) past_valid <= 1'b0;
            else     past_valid <= 1'b1;
         end

         // Independent record of which antecedent should be falling due now.
         if (LATENCY == 0) begin : g_hist0
            assign expect_due = antecedent;
         end else begin : g_hist
            logic [LATENCY-1:0] hist;
            always_ff @(posedge clk) begin
               if (rst) hist <= '0;
               else     hist <= (hist << 1) | LATENCY'(antecedent);
            end
            assign expect_due = hist[LATENCY-1];
         end

         a_latency: assert property (@(posedge clk) disable iff (rst)
            (expect_due && consequent_ready && !overflow) |-> consequent);
         a_bound: assert property (@(posedge clk) disable iff (rst || !past_valid)
            pending <= PENDING_W'(MAX_PENDING));
         a_sticky: assert property (@(posedge clk) disable iff (rst)
            (past_valid && $past(overflow)) |-> overflow);
         a_avail: assert property (@(posedge clk) disable iff (rst)
            consequent |-> avail);
      end
   endgenerate

endmodule

// File: tb/tb_implication_responder.sv
// tb/tb_implication_responder.sv - randomized check of two responder configurations against a due-time model
module tb_implication_responder;

   localparam int LAT0 = 2;
   localparam int MAXP0 = 3;
   localparam int LAT1 = 0;
   localparam int MAXP1 = 4;
   localparam int NCYC = 8192;

   logic       clk = 1'b0;
   logic       rst;
   logic       ant;
   logic       rdy;
   logic       cons [2];
   logic [3:0] pend [2];
   logic       ovf  [2];

   int  checks = 0;
   int  fails  = 0;
   int  cyc    = 0;
   int  pend_m [2];
   bit  ovf_m  [2];
   bit  due_at [2][0:NCYC-1];
   int  lat_m  [2];
   int  maxp_m [2];

   always #5 clk = ~clk;

   implication_responder #(.LATENCY(LAT0), .MAX_PENDING(MAXP0), .EMBED_CHECKS(1)) u_dut0 (
      .clk              (clk),
      .rst              (rst),
      .antecedent       (ant),
      .consequent_ready (rdy),
      .consequent       (cons[0]),
      .pending          (pend[0]),
      .overflow         (ovf[0])
   );

   implication_responder #(.LATENCY(LAT1), .MAX_PENDING(MAXP1), .EMBED_CHECKS(1)) u_dut1 (
      .clk              (clk),
      .rst              (rst),
      .antecedent       (ant),
      .consequent_ready (rdy),
      .consequent       (cons[1]),
      .pending          (pend[1]),
      .overflow         (ovf[1])
   );

   task automatic check(input string tag, input int k, input int obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s dut%0d cycle %0d: observed %0d expected %0d", tag, k, cyc, obs, exp);
      end
   endtask

   // Apply inputs for one cycle, compare outputs, then advance the model past the edge.
   task automatic step(input bit a, input bit r, input bit rs);
      @(negedge clk);
      ant = a;
      rdy = r;
      rst = rs;
      #1;
      for (int k = 0; k < 2; k++) begin
         bit due;
         bit ec;
         int n;
         due = (lat_m[k] == 0) ? a : due_at[k][cyc];
         ec  = ((pend_m[k] > 0) || due) && r;
         check("consequent", k, int'(cons[k]), int'(ec));
         check("pending", k, int'(pend[k]), pend_m[k]);
         check("overflow", k, int'(ovf[k]), int'(ovf_m[k]));
         if (rs) begin
            pend_m[k] = 0;
            ovf_m[k]  = 1'b0;
            for (int j = 1; j <= 8; j++) due_at[k][cyc+j] = 1'b0;
         end else begin
            n = pend_m[k] + int'(due) - int'(ec);
            if (n > maxp_m[k]) begin
               n = maxp_m[k];
               ovf_m[k] = 1'b1;
            end
            pend_m[k] = n;
            if (a && lat_m[k] > 0) due_at[k][cyc+lat_m[k]] = 1'b1;
         end
      end
      cyc++;
   endtask

   initial begin
      rst = 1'b1;
      ant = 1'b0;
      rdy = 1'b0;
      lat_m[0] = LAT0;  maxp_m[0] = MAXP0;
      lat_m[1] = LAT1;  maxp_m[1] = MAXP1;
      for (int k = 0; k < 2; k++) begin
         pend_m[k] = 0;
         ovf_m[k]  = 1'b0;
      end

      // Reset, including an antecedent that must be discarded.
      step(0, 0, 1);
      step(1, 1, 1);

      // Ready high: pulses, back-to-back pulses, no backlog.
      step(0, 1, 0);
      step(1, 1, 0);
      step(1, 1, 0);
      step(0, 1, 0);
      step(1, 1, 0);
      for (int i = 0; i < 4; i++) step(0, 1, 0);

      // Backlog with ready low, then drain.
      step(1, 0, 0);
      step(1, 0, 0);
      step(0, 0, 0);
      step(0, 0, 0);
      for (int i = 0; i < 5; i++) step(0, 1, 0);

      // Drive both configurations into overflow, then show it is sticky through a drain.
      for (int i = 0; i < 8; i++) step(1, 0, 0);
      for (int i = 0; i < 8; i++) step(0, 1, 0);

      // Reset with requests in flight: nothing may emerge afterwards.
      step(1, 0, 0);
      step(0, 0, 1);
      for (int i = 0; i < 5; i++) step(0, 1, 0);

      // Randomized traffic with occasional resets.
      for (int i = 0; i < 600; i++) begin
         bit a;
         bit r;
         bit rs;
         a  = ($urandom_range(0, 99) < 45);
         r  = ($urandom_range(0, 99) < ((i / 100) % 2 == 0 ? 70 : 35));
         rs = ($urandom_range(0, 99) < 2);
         step(a, r, rs);
      end

      $display("%0d/%0d checks passed", checks - fails, checks);
      $finish;
   end

endmodule

// File: doc/implication_responder.md
IMPLICATION_RESPONDER -- requirements
Module: implication_responder

Interface
REQ-001 The block SHALL have parameter LATENCY, default 1, meaning the cycles from an antecedent pulse to its due consequent (legal range 0..8).
REQ-002 The block SHALL have parameter MAX_PENDING, default 4, meaning the due-but-unissued consequents held before overflow (legal range 1..15).
REQ-003 The block SHALL have parameter EMBED_CHECKS, default 1, meaning embedded concurrent assertions are present when 1.
REQ-004 clk  input  1  sole clock; all state updates on posedge clk.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 antecedent  input  1  request pulse; each high cycle is one independent request.
REQ-007 consequent_ready  input  1  downstream can accept a consequent this cycle.
REQ-008 consequent  output  1  response issued; one high cycle retires one request.
REQ-009 pending  output  4  count of due, unissued consequents.
REQ-010 overflow  output  1  sticky error; a due consequent was lost.

Function
REQ-011 Each antecedent-high cycle at edge N SHALL make one consequent due in cycle N+LATENCY, tracked by a LATENCY-stage delay line.
REQ-012 LATENCY=0: due SHALL equal antecedent in the same cycle (combinational path antecedent->consequent permitted only in this case).
REQ-013 due_now = delay-line output (or antecedent when LATENCY=0); avail = (pending>0) || due_now.
REQ-014 consequent SHALL equal avail && consequent_ready, combinationally.
REQ-015 Next pending SHALL equal pending + due_now - consequent, with the stored value never exceeding MAX_PENDING.
REQ-016 Due and issue in the same cycle SHALL leave pending unchanged; the oldest due request is retired first (responses are indistinguishable, so ordering is count-only).
REQ-017 If pending==MAX_PENDING, due_now=1 and consequent=0, pending SHALL stay at MAX_PENDING and overflow SHALL set and hold until reset.
REQ-018 With consequent_ready held high and no overflow, consequent SHALL be high exactly in cycles N+LATENCY for every antecedent at N, and pending SHALL stay 0.
REQ-019 Back-to-back antecedents SHALL produce back-to-back consequents; no bubbles are inserted.
REQ-020 pending SHALL never wrap; width arithmetic SHALL be done at 5 bits and saturated.
REQ-021 When EMBED_CHECKS=1, assertions SHALL check: REQ-018 as antecedent |-> ##LATENCY consequent under ready-high and no-overflow; pending<=MAX_PENDING; overflow never falls outside reset; consequent implies avail.
REQ-022 Assertions using $past SHALL be gated by a past_valid register cleared by rst, so cycle 0 and the cycle after reset never fire.

Reset
REQ-023 While rst=1 at an edge: delay line cleared, pending=0, overflow=0, past_valid=0.
REQ-024 consequent SHALL be 0 in any cycle whose preceding edge sampled rst=1, except through the LATENCY=0 combinational path.
REQ-025 Antecedents sampled with rst=1 SHALL be discarded.
REQ-026 Reset mid-operation SHALL drop all in-flight and pending requests; no consequent for them appears after rst falls.

Structure
REQ-027 The shared package implication_pkg SHALL hold LATENCY_MAX=8, PENDING_MAX=15 and PENDING_W=4.
REQ-028 The delay line SHALL be a sub-module pulse_delay_line (params DEPTH; ports clk, rst, din, dout), which is a pass-through when DEPTH=0.
REQ-029 Parameter legality SHALL be checked at elaboration and reported as a fatal error when violated.

Verification
REQ-030 LATENCY=1, ready=1, antecedent pulses at cycles 3,4,7 -> consequent high at 4,5,8 only; pending=0 throughout.
REQ-031 LATENCY=0, ready=1, antecedent at cycle 5 -> consequent high in cycle 5 (same cycle).
REQ-032 LATENCY=2, ready=0 cycles 0-9, antecedent at 1,2,3 -> pending=1,2,3 after cycles 3,4,5; ready=1 at 10 -> consequent at 10,11,12, pending 0 after 12.
REQ-033 MAX_PENDING=2, LATENCY=1, ready=0, antecedent at 1,2,3 -> pending saturates at 2, overflow=1 after cycle 4 and stays 1 through ready=1 drain.
REQ-034 LATENCY=3, antecedent at 2, rst at 3 -> no consequent at 5; pending=0, overflow=0.
REQ-035 Formal run, EMBED_CHECKS=1, depth 20, unconstrained inputs -> all embedded assertions prove, with no $past failure at cycle 0.
